// File: rtl/fetch_queue_pkg.sv
// Shared constants for the IF->ID fetch queue: word width, the NOP that ID
// substitutes for an empty slot, and the pointer-width helper.
package fetch_queue_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: DEPTH x W flops, one write port and one
// combinational read port. Contents are not reset; the owner masks reads.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [DEPTH-1:0][W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// In-order {pc, instr} queue between IF and ID. Occupancy is tracked by an
// explicit counter; a redirect (flush) empties the queue in one cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WORD_W,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_pc,
  input  logic [AW-1:0] in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_instr,
  output logic [CW-1:0] count
);
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  logic [2*AW-1:0] head;

  // Full/empty come from the counter, so the pointers can wrap freely.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Wrong-path words arriving with a flush are never written.
  fetch_queue_mem #(.DEPTH(DEPTH), .W(2*AW), .PW(PW)) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign out_pc    = out_valid ? head[2*AW-1:AW] : '0;
  assign out_instr = out_valid ? head[AW-1:0]    : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a table of per-cycle vectors with
// hand-computed post-edge state, plus hand sequences for reset corners.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  typedef struct {
    string       name;
    logic        fl, iv, ordy;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        ir, ov;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  function automatic vec_t mk(input string nm, input logic fl, input logic iv,
                              input logic [31:0] pc, input logic ordy,
                              input logic [2:0] cnt, input logic ir, input logic ov,
                              input logic [31:0] epc);
    vec_t v;
    v.name = nm; v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.cnt = cnt; v.ir = ir; v.ov = ov; v.epc = epc;
    return v;
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    flush = fl; in_valid = iv; in_pc = pc; in_instr = instr_of(pc); out_ready = ordy;
  endtask

  task automatic check(input string nm, input logic [2:0] cnt, input logic ir,
                       input logic ov, input logic [31:0] epc);
    logic [31:0] ein;
    ein = ov ? instr_of(epc) : 32'h0;
    n_vec++;
    if (count !== cnt || in_ready !== ir || out_valid !== ov ||
        out_pc !== epc || out_instr !== ein) begin
      n_err++;
      $display("FAIL %s: got cnt=%0d ir=%b ov=%b pc=%h ins=%h, want cnt=%0d ir=%b ov=%b pc=%h ins=%h",
               nm, count, in_ready, out_valid, out_pc, out_instr, cnt, ir, ov, epc, ein);
    end
  endtask

  initial begin
    // Fill with ID stalled, then a full-cycle push attempt, then drain.
    vecs.push_back(mk("fill0",     0, 1, 32'h0,   0, 1, 1, 1, 32'h0));
    vecs.push_back(mk("fill4",     0, 1, 32'h4,   0, 2, 1, 1, 32'h0));
    vecs.push_back(mk("fill8",     0, 1, 32'h8,   0, 3, 1, 1, 32'h0));
    vecs.push_back(mk("fillC",     0, 1, 32'hC,   0, 4, 0, 1, 32'h0));
    vecs.push_back(mk("full_drop", 0, 1, 32'h10,  0, 4, 0, 1, 32'h0));
    vecs.push_back(mk("full_pop",  0, 1, 32'h10,  1, 3, 1, 1, 32'h4));
    vecs.push_back(mk("drain8",    0, 0, 32'h0,   1, 2, 1, 1, 32'h8));
    vecs.push_back(mk("drainC",    0, 0, 32'h0,   1, 1, 1, 1, 32'hC));
    vecs.push_back(mk("drain_end", 0, 0, 32'h0,   1, 0, 1, 0, 32'h0));
    vecs.push_back(mk("empty_pop", 0, 0, 32'h0,   1, 0, 1, 0, 32'h0));
    // Two entries, then ten push+pop cycles to wrap the pointers.
    vecs.push_back(mk("pp_a",      0, 1, 32'h100, 0, 1, 1, 1, 32'h100));
    vecs.push_back(mk("pp_b",      0, 1, 32'h104, 0, 2, 1, 1, 32'h100));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk($sformatf("pushpop%0d", k), 0, 1, 32'h108 + 32'(4*k), 1,
                        2, 1, 1, 32'h104 + 32'(4*k)));
    // count=3, then flush with a wrong-path push and a pop in the same cycle.
    vecs.push_back(mk("pre_flush", 0, 1, 32'h200, 0, 3, 1, 1, 32'h128));
    vecs.push_back(mk("flush",     1, 1, 32'h40,  1, 0, 1, 0, 32'h0));
    vecs.push_back(mk("post_fl80", 0, 1, 32'h80,  0, 1, 1, 1, 32'h80));
    vecs.push_back(mk("post_fl84", 0, 1, 32'h84,  0, 2, 1, 1, 32'h80));

    rst = 1'b0;
    drive(0, 0, 32'h0, 0);
    #1 check("reset_async", 0, 1, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", 0, 1, 0, 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      if (vecs[i].fl) begin
        // During the flush cycle in_ready still reflects the current count.
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL flush_in_ready: got %b want 1", in_ready);
        end
      end
      @(posedge clk);
      #1 check(vecs[i].name, vecs[i].cnt, vecs[i].ir, vecs[i].ov, vecs[i].epc);
    end

    // Async reset between edges with two entries queued.
    drive(0, 1, 32'h90, 0);
    #2 rst = 1'b0;
    #1 check("async_rst", 0, 1, 0, 32'h0);
    @(posedge clk);
    #1 check("rst_held_push", 0, 1, 0, 32'h0);
    rst = 1'b1;
    drive(0, 1, 32'h300, 0);
    @(posedge clk);
    #1 check("first_push", 1, 1, 1, 32'h300);
    drive(0, 1, 32'h304, 0);
    @(posedge clk);
    #1 check("stall_stable", 2, 1, 1, 32'h300);
    drive(0, 0, 32'h0, 1);
    @(posedge clk);
    #1 check("pop_after", 1, 1, 1, 32'h304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
